// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - stream-in / result-out bundle of the partial-sum collector
// The slave modport is the collector's view; the master modport drives it.
interface psum_collector_if #(
  parameter int BW2   = 17,
  parameter int OW    = 24,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           i_valid;
  logic [BW2-1:0] i_psum;
  logic           o_ready;
  logic           i_clear;
  logic           o_valid;
  logic [OW-1:0]  o_data;
  logic           i_ready;
  logic [CW-1:0]  o_count;
  logic           o_ovf;

  modport slave (
    input  i_valid, i_psum, i_clear, i_ready,
    output o_ready, o_valid, o_data, o_count, o_ovf
  );

  modport master (
    output i_valid, i_psum, i_clear, i_ready,
    input  o_ready, o_valid, o_data, o_count, o_ovf
  );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - reduces every K partial sums into one result queued in a small FIFO
// PSUM_COLLECT_SAT_EN: clamp on overflow instead of two's-complement wrap.
module psum_collector #(
  parameter int BW2   = 17,
  parameter int OW    = 24,
  parameter int K     = 4,
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  psum_collector_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNTW-1:0] LAST    = CNTW'(K - 1);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [OW-1:0]   SAT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]   SAT_MIN = {1'b1, {(OW-1){1'b0}}};

  logic [OW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   mem [DEPTH];

  logic [OW:0]   sum;
  logic          sum_ovf;
  logic [OW-1:0] res;
  logic          is_last;
  logic          accept;
  logic          push;
  logic          pop;

  // One guard bit above OW catches overflow of the signed add.
  assign sum     = {acc_q[OW-1], acc_q} + {{(OW+1-BW2){bus.i_psum[BW2-1]}}, bus.i_psum};
  assign sum_ovf = sum[OW] ^ sum[OW-1];

`ifdef PSUM_COLLECT_SAT_EN
  assign res = sum_ovf ? (sum[OW] ? SAT_MIN : SAT_MAX) : sum[OW-1:0];
`else
  assign res = sum[OW-1:0];
`endif

  assign is_last     = (cnt_q == LAST);
  assign bus.o_ready = !is_last || (count_q != FULL);
  assign accept      = bus.i_valid && bus.o_ready && !bus.i_clear;
  assign push        = accept && is_last;
  assign pop         = bus.o_valid && bus.i_ready && !bus.i_clear;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_clear) begin
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        ovf_d = ovf_q | sum_ovf;
        if (is_last) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d = res;
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= res;
  end

  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = bus.o_valid ? mem[rd_ptr_q] : '0;
  assign bus.o_count = count_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: doc/psum_collector.md
# psum_collector

Drain-side companion to the processing-element chain: consumes the `o_psum` stream leaving the last PE stage and reduces every K consecutive partial sums into one wide result. Completed results are buffered in a small FIFO and handed downstream over a valid/ready handshake. It sits between the PE array output and the result writeback logic.

## Interface
- `BW2`, 17: width of incoming signed partial sum (matches PE `o_psum`)
- `OW`, 24: width of accumulated signed result, OW ≥ BW2
- `K`, 4: partial sums reduced per result, K ≥ 1
- `DEPTH`, 4: result FIFO entries, power of two, ≥ 2

Ports:
- `i_clk`, input, 1: clock, all state on rising edge
- `i_rst_n`, input, 1: asynchronous active-low reset
- `i_valid`, input, 1: `i_psum` valid this cycle
- `i_psum`, input, BW2: signed partial sum from PE chain
- `o_ready`, output, 1: beat on `i_psum` accepted when `i_valid && o_ready`
- `i_clear`, input, 1: synchronous flush of accumulator, counter and FIFO
- `o_valid`, output, 1: FIFO head valid
- `o_data`, output, OW: FIFO head, signed
- `i_ready`, input, 1: downstream pops head when `o_valid && i_ready`
- `o_count`, output, $clog2(DEPTH)+1: FIFO occupancy
- `o_ovf`, output, 1: sticky, set on any accumulation overflow

## Operation
- State: accumulator `acc` (OW, signed), beat counter `cnt` (0..K-1), FIFO, `o_ovf`.
- Accept: `sum = acc + sext(i_psum)` computed at OW+1 bits; overflow when bit OW differs from bit OW-1.
- `cnt < K-1`: `acc <= sum[OW-1:0]` (or saturated value, see Configuration), `cnt <= cnt+1`.
- `cnt == K-1`: push sum into FIFO, `acc <= 0`, `cnt <= 0`. With K=1 every beat is pushed directly.
- `o_ready = (cnt != K-1) || (o_count != DEPTH)`; non-final beats are never stalled. No combinational path from `i_ready` to `o_ready`.
- Pop: `o_valid && i_ready` removes head; the next entry appears on `o_data` in the following cycle.
- Simultaneous push and pop with FIFO not full: both happen, occupancy unchanged.
- FIFO full with pop in same cycle: final beat still not accepted that cycle (`o_ready` stays 0); it is accepted the next cycle.
- `i_clear`: next edge sets `acc=0`, `cnt=0`, FIFO empty. It wins over a concurrent accept or pop, and both of those are discarded. `o_ovf` is cleared too.
- `o_ovf` sets on overflow of any accepted beat and holds until reset or `i_clear`.
- `o_data` holds its value while `o_valid && !i_ready`.

## Timing
- Reset (async assert, sync release by system): `acc=0`, `cnt=0`, `o_valid=0`, `o_data=0`, `o_count=0`, `o_ovf=0`. `o_ready=1` once out of reset.
- Latency: final beat accepted at edge N gives `o_valid=1` with that result after edge N (visible cycle N+1).
- Throughput: one beat per cycle sustained while downstream pops every cycle.
- Reset mid-accumulation: partial `acc` is lost, and the next accepted beat is treated as beat 0.

## Configuration
- `PSUM_COLLECT_SAT_EN` defined: on overflow, `acc` and the pushed value clamp to +2^(OW-1)-1 or -2^(OW-1) according to the sign of the true sum.
- Not defined: two's-complement wrap to OW bits.
- `o_ovf` is set on overflow in both builds.

## Test plan
- K=4: beats 100, -5, 20, 1 -> one result 116, `o_valid` the cycle after the 4th beat, `o_ovf=0`.
- DEPTH=4, `i_ready=0`, 20 beats of 1 -> 4 results of 4 queued, `o_count=4`, `o_ready=0` while `cnt=3`. Raise `i_ready` -> results drain in order and the 5th result is accepted.
- Continuous beats with `i_ready=1` -> `o_valid` every 4th cycle, `o_ready` never drops, occupancy ≤ 1.
- OW=18, 4 beats of 65535 -> `o_ovf=1`. With `PSUM_COLLECT_SAT_EN` the result is 131071; without it the result is 262140 - 262144 = -4.
- After 2 beats plus 2 queued results, assert `i_clear` together with `i_valid` -> `o_count=0`, `o_valid=0`. The next 4 beats of 10 -> result 40.
- Assert `i_rst_n=0` asynchronously mid-accumulation -> all outputs at reset values before the next edge. After release, beats 1, 2, 3, 4 -> result 10.
